alu_exec_unit: RTL

//   Parametrised ALU control decode plus registered execute stage for the RV32I core.

---
 rtl/alu_exec_unit_if.sv | 29 ++
 rtl/alu_exec_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - operation/result handshake bundle for the ALU execute stage
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic [3:0]      alu_ctrl;

    modport master (
        output in_valid, alu_op, op, funct3, funct7, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal, alu_ctrl
    );

    modport slave (
        input  in_valid, alu_op, op, funct3, funct7, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, illegal, alu_ctrl
    );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - RV32I ALU decode plus registered execute stage with handshakes
// Define ALU_MUL_EN to add the iterative shift-add multiplier (RV32M MUL).
module alu_exec_unit #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    alu_exec_unit_if.slave  bus
);
    localparam logic [3:0] CTRL_ADD  = 4'd0;
    localparam logic [3:0] CTRL_SUB  = 4'd1;
    localparam logic [3:0] CTRL_AND  = 4'd2;
    localparam logic [3:0] CTRL_OR   = 4'd3;
    localparam logic [3:0] CTRL_XOR  = 4'd4;
    localparam logic [3:0] CTRL_SLT  = 4'd5;
    localparam logic [3:0] CTRL_SLTU = 4'd6;
    localparam logic [3:0] CTRL_SLL  = 4'd7;
    localparam logic [3:0] CTRL_SRL  = 4'd8;
    localparam logic [3:0] CTRL_SRA  = 4'd9;
    localparam logic [3:0] CTRL_MUL  = 4'd10;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic [3:0]      alu_ctrl_q, alu_ctrl_d;

    logic            in_ready;
    logic            in_idle;
    logic            m_enc;
    logic [3:0]      ctrl_dec;
    logic            illegal_dec;
    logic            mul_dec;
    logic [XLEN-1:0] exec_res;
    logic [SHW-1:0]  shamt;
    logic            unused_op_bits;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] partial;
    logic [XLEN-1:0] acc_next;
`endif

    assign unused_op_bits = ^{bus.op[6], bus.op[4:0]};
    assign shamt          = bus.src_b[SHW-1:0];
    assign m_enc          = (bus.alu_op == 2'b10) && bus.op[5] && (bus.funct7 == 7'b0000001);

    always_comb begin
        ctrl_dec    = CTRL_ADD;
        illegal_dec = 1'b0;
        mul_dec     = 1'b0;
        case (bus.alu_op)
            2'b01: ctrl_dec = CTRL_SUB;
            2'b10: begin
                if (m_enc) begin
`ifdef ALU_MUL_EN
                    if (bus.funct3 == 3'b000) begin
                        mul_dec  = 1'b1;
                        ctrl_dec = CTRL_MUL;
                    end else begin
                        illegal_dec = 1'b1;
                    end
`else
                    illegal_dec = 1'b1;
`endif
                end else begin
                    case (bus.funct3)
                        3'b000:  ctrl_dec = (bus.op[5] && bus.funct7[5]) ? CTRL_SUB : CTRL_ADD;
                        3'b001:  ctrl_dec = CTRL_SLL;
                        3'b010:  ctrl_dec = CTRL_SLT;
                        3'b011:  ctrl_dec = CTRL_SLTU;
                        3'b100:  ctrl_dec = CTRL_XOR;
                        3'b101:  ctrl_dec = bus.funct7[5] ? CTRL_SRA : CTRL_SRL;
                        3'b110:  ctrl_dec = CTRL_OR;
                        default: ctrl_dec = CTRL_AND;
                    endcase
                end
            end
            default: ctrl_dec = CTRL_ADD;
        endcase
    end

    // Illegal ops report ADD as their control code with a forced-zero result.
    always_comb begin
        exec_res = '0;
        if (!illegal_dec) begin
            case (ctrl_dec)
                CTRL_ADD:  exec_res = bus.src_a + bus.src_b;
                CTRL_SUB:  exec_res = bus.src_a - bus.src_b;
                CTRL_AND:  exec_res = bus.src_a & bus.src_b;
                CTRL_OR:   exec_res = bus.src_a | bus.src_b;
                CTRL_XOR:  exec_res = bus.src_a ^ bus.src_b;
                CTRL_SLT:  exec_res = XLEN'($signed(bus.src_a) < $signed(bus.src_b));
                CTRL_SLTU: exec_res = XLEN'(bus.src_a < bus.src_b);
                CTRL_SLL:  exec_res = bus.src_a << shamt;
                CTRL_SRL:  exec_res = bus.src_a >> shamt;
                CTRL_SRA:  exec_res = XLEN'($signed(bus.src_a) >>> shamt);
                default:   exec_res = '0;
            endcase
        end
    end

`ifdef ALU_MUL_EN
    assign in_idle  = (state_q == S_IDLE);
    assign partial  = mplier_q[0] ? mcand_q : '0;
    assign acc_next = acc_q + partial;
`else
    assign in_idle  = 1'b1;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        alu_ctrl_d  = alu_ctrl_q;
        in_ready    = 1'b0;
`ifdef ALU_MUL_EN
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
`endif
        if (in_idle) begin
            in_ready = !out_valid_q || bus.out_ready;
            if (bus.out_ready) begin
                out_valid_d = 1'b0;
            end
            if (bus.in_valid && in_ready) begin
`ifdef ALU_MUL_EN
                if (mul_dec) begin
                    mcand_d     = bus.src_a;
                    mplier_d    = bus.src_b;
                    acc_d       = '0;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                    state_d     = S_MUL;
                end else
`endif
                begin
                    result_d    = exec_res;
                    zero_d      = (exec_res == '0);
                    illegal_d   = illegal_dec;
                    alu_ctrl_d  = ctrl_dec;
                    out_valid_d = 1'b1;
                end
            end
        end
`ifdef ALU_MUL_EN
        case (state_q)
            S_MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Final partial product folds straight into the result register.
                if (cnt_q == SHW'(XLEN - 1)) begin
                    result_d    = acc_next;
                    zero_d      = (acc_next == '0);
                    illegal_d   = 1'b0;
                    alu_ctrl_d  = CTRL_MUL;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: ;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            alu_ctrl_q  <= CTRL_ADD;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            alu_ctrl_q  <= alu_ctrl_d;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;
    assign bus.alu_ctrl  = alu_ctrl_q;
endmodule
